// File: rtl/seg_scan_driver.sv
// seg_scan_driver
// Scans a 32-bit value onto an 8-digit multiplexed seven-segment display as
// hex nibbles. Inputs are latched once per frame so a digit never shows a
// mix of old and new values. Each digit gets a decimal point, and leading
// zeros can be blanked. A short guard blank after each digit change stops
// ghosting on the shared segment lines. All outputs are registered.
module seg_scan_driver #(
  parameter int SCAN_DIV = 50000,
  parameter int GUARD    = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data,
  input  logic [7:0]  dp,
  input  logic        lzb,
  output logic [2:0]  which,
  output logic        enable,
  output logic [7:0]  seg
);

  localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int GRD_W = (GUARD > 1) ? $clog2(GUARD + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(SCAN_DIV - 1);
  localparam logic [GRD_W-1:0] GRD_LOAD = GRD_W'(GUARD);

  // Active-low {g,f,e,d,c,b,a} pattern for one hex nibble
  function automatic logic [6:0] hex7(input logic [3:0] nib);
    logic [6:0] code;
    case (nib)
      4'h0: code = 7'h40;
      4'h1: code = 7'h79;
      4'h2: code = 7'h24;
      4'h3: code = 7'h30;
      4'h4: code = 7'h19;
      4'h5: code = 7'h12;
      4'h6: code = 7'h02;
      4'h7: code = 7'h78;
      4'h8: code = 7'h00;
      4'h9: code = 7'h10;
      4'hA: code = 7'h08;
      4'hB: code = 7'h03;
      4'hC: code = 7'h46;
      4'hD: code = 7'h21;
      4'hE: code = 7'h06;
      default: code = 7'h0E;
    endcase
    return code;
  endfunction

  // True when digit k is a leading zero: it and every digit above it are
  // zero. Digit 0 is never a leading zero, so a value of 0 still shows "0".
  function automatic logic lead_zero(input logic [31:0] v, input logic [2:0] k);
    logic upper_zero;
    upper_zero = 1'b1;
    for (int j = 0; j < 8; j++) begin
      if (j >= int'(k) && v[4*j +: 4] != 4'h0) upper_zero = 1'b0;
    end
    return upper_zero && (k != 3'd0);
  endfunction

  logic [CNT_W-1:0] cnt_p0;
  logic [2:0]       idx_p0;
  logic [GRD_W-1:0] guard_p0;
  logic [31:0]      data_sh;
  logic [7:0]       dp_sh;
  logic             lzb_sh;
  logic             prime;

  logic       tick;
  logic       load_sh;
  logic       blanked;
  logic       suppressed;
  logic [3:0] nibble;

  assign tick       = (cnt_p0 == CNT_MAX);
  assign load_sh    = prime | (tick & (idx_p0 == 3'd7));
  assign blanked    = (guard_p0 != '0);
  assign nibble     = data_sh[{idx_p0, 2'b00} +: 4];
  assign suppressed = lzb_sh & lead_zero(data_sh, idx_p0) & ~dp_sh[idx_p0];

  // ---- stage p0: prescaler, digit index and guard countdown ----
  // Prescaler produces one tick per digit slot
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_p0 <= '0;
    else if (tick) cnt_p0 <= '0;
    else cnt_p0 <= cnt_p0 + 1'b1;
  end

  // Digit index advances on each tick and wraps naturally from 7 to 0
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) idx_p0 <= 3'd0;
    else if (tick) idx_p0 <= idx_p0 + 3'd1;
  end

  // Guard reloads on every digit change, then counts down to zero
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) guard_p0 <= '0;
    else if (tick) guard_p0 <= GRD_LOAD;
    else if (guard_p0 != '0) guard_p0 <= guard_p0 - 1'b1;
  end

  // Shadow registers load once after reset, then only at the frame boundary
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_sh <= '0;
      dp_sh   <= '0;
      lzb_sh  <= 1'b0;
      prime   <= 1'b1;
    end else begin
      prime <= 1'b0;
      if (load_sh) begin
        data_sh <= data;
        dp_sh   <= dp;
        lzb_sh  <= lzb;
      end
    end
  end

  // ---- stage p1: registered display outputs ----
  // Outputs trail the index and guard by one clock so they all change together
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      which  <= 3'd0;
      enable <= 1'b0;
      seg    <= 8'hFF;
    end else begin
      which  <= idx_p0;
      enable <= ~blanked & ~suppressed;
      if (blanked || suppressed) seg <= 8'hFF;
      else seg <= {~dp_sh[idx_p0], hex7(nibble)};
    end
  end

endmodule
